// File: rtl/run_sequencer_if.sv
// Run sequencer bus interface.
// Bundles the run-control handshakes, the UART/processor candidate
// data-memory ports, the muxed data-memory port and the status outputs.
//   slave  : the sequencer (requests/pulses/candidates in, mux/status out)
//   master : the controlling environment (the mirror image)
interface run_sequencer_if #(
    parameter int DATA_MEM_WIDTH      = 48,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int TIME_WIDTH          = 26,
    parameter int RUN_COUNT_WIDTH     = 8
);
    // run requests and done pulses
    logic                           startN;
    logic                           rerunN;
    logic                           ins_received;
    logic                           data_received;
    logic                           data_transmitted;
    logic                           processDone;
    // candidate data memory ports
    logic [DATA_MEM_ADDR_WIDTH-1:0] uart_addr;
    logic [DATA_MEM_ADDR_WIDTH-1:0] proc_addr;
    logic [DATA_MEM_WIDTH-1:0]      uart_data;
    logic [DATA_MEM_WIDTH-1:0]      proc_data;
    logic                           uart_wrEn;
    logic                           proc_wrEn;
    // muxed data memory port
    logic [DATA_MEM_ADDR_WIDTH-1:0] dataMemAddr;
    logic [DATA_MEM_WIDTH-1:0]      dataMemIn;
    logic                           dataMemWrEn;
    // control pulses and status
    logic                           processStart;
    logic                           dmem_txStartN;
    logic [2:0]                     state;
    logic [TIME_WIDTH-1:0]          timeDuration;
    logic [RUN_COUNT_WIDTH-1:0]     runCount;
    logic                           timeout;

    modport slave (
        input  startN, rerunN, ins_received, data_received, data_transmitted, processDone,
        input  uart_addr, proc_addr, uart_data, proc_data, uart_wrEn, proc_wrEn,
        output dataMemAddr, dataMemIn, dataMemWrEn,
        output processStart, dmem_txStartN, state, timeDuration, runCount, timeout
    );

    modport master (
        output startN, rerunN, ins_received, data_received, data_transmitted, processDone,
        output uart_addr, proc_addr, uart_data, proc_data, uart_wrEn, proc_wrEn,
        input  dataMemAddr, dataMemIn, dataMemWrEn,
        input  processStart, dmem_txStartN, state, timeDuration, runCount, timeout
    );
endinterface

// File: rtl/run_sequencer.sv
// Run sequencer: steps a processor through load (instruction + data memory),
// execute, and result transmission, with an optional execution watchdog.
// Ports:
//   clk   - system clock, rising edge
//   rstN  - synchronous active-low reset
//   bus   - run_sequencer_if.slave: requests, done pulses, memory mux, status
// The start/transmit pulses and the memory mux are combinational from the
// registered state; all of them are forced inactive while rstN is low so a
// reset cycle never leaks a pulse or a write.
module run_sequencer #(
    parameter int DATA_MEM_WIDTH      = 48,
    parameter int DATA_MEM_ADDR_WIDTH = 12,
    parameter int TIME_WIDTH          = 26,
    parameter int TIMEOUT_CYCLES      = 0,
    parameter int RUN_COUNT_WIDTH     = 8
) (
    input  logic          clk,
    input  logic          rstN,
    run_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RX_IMEM = 3'd1,
        RX_DMEM = 3'd2,
        EXEC    = 3'd3,
        TX_DMEM = 3'd4,
        FINISH  = 3'd5,
        ERROR   = 3'd6
    } state_e;

    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);
    // timeDuration value seen in the last allowed EXEC cycle
    localparam logic [TIME_WIDTH-1:0] TO_LIM =
        TIME_WIDTH'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    state_e                     state_q, state_d;
    logic [TIME_WIDTH-1:0]      time_q;
    logic [RUN_COUNT_WIDTH-1:0] runs_q;
    logic                       timeout_q;
    logic                       armed_q;
    logic                       wdog_hit;
    logic                       enter_exec;
    logic                       sel_uart, sel_proc;

    // next-state decode
    always_comb begin
        state_d  = state_q;
        wdog_hit = 1'b0;
        case (state_q)
            IDLE:    if (!bus.startN) state_d = RX_IMEM;
            RX_IMEM: if (bus.ins_received) state_d = RX_DMEM;
            RX_DMEM: if (bus.data_received) state_d = EXEC;
            EXEC: begin
                // a done pulse in the limit cycle beats the watchdog
                if (bus.processDone) begin
                    state_d = TX_DMEM;
                end else if (WDOG_EN && time_q == TO_LIM) begin
                    state_d  = ERROR;
                    wdog_hit = 1'b1;
                end
            end
            TX_DMEM: if (bus.data_transmitted) state_d = FINISH;
            FINISH: begin
                if (armed_q) begin
                    if (!bus.startN)      state_d = RX_IMEM;
                    else if (!bus.rerunN) state_d = RX_DMEM;
                end
            end
            ERROR:   if (armed_q && !bus.startN) state_d = RX_IMEM;
            default: state_d = IDLE;
        endcase
    end

    assign enter_exec = (state_q != EXEC) && (state_d == EXEC);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q   <= IDLE;
            time_q    <= '0;
            runs_q    <= '0;
            timeout_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q <= state_d;

            // saturating EXEC cycle counter, held outside EXEC
            if (enter_exec)
                time_q <= '0;
            else if (state_q == EXEC && time_q != '1)
                time_q <= time_q + TIME_WIDTH'(1);

            if (wdog_hit)
                timeout_q <= 1'b1;
            else if (enter_exec)
                timeout_q <= 1'b0;

            if (state_q == EXEC && state_d == TX_DMEM)
                runs_q <= runs_q + RUN_COUNT_WIDTH'(1);

            // requests still held from the previous run must be released
            // before FINISH/ERROR will act on them again
            if ((state_d == FINISH || state_d == ERROR) && state_d != state_q)
                armed_q <= 1'b0;
            else if (bus.startN && bus.rerunN)
                armed_q <= 1'b1;
        end
    end

    assign sel_uart = rstN && (state_q == RX_DMEM || state_q == TX_DMEM);
    assign sel_proc = rstN && (state_q == EXEC);

    assign bus.dataMemAddr = sel_uart ? bus.uart_addr : (sel_proc ? bus.proc_addr : '0);
    assign bus.dataMemIn   = sel_uart ? bus.uart_data : (sel_proc ? bus.proc_data : '0);
    assign bus.dataMemWrEn = sel_uart ? bus.uart_wrEn : (sel_proc ? bus.proc_wrEn : 1'b0);

    assign bus.processStart  = rstN && (state_q == RX_DMEM) && bus.data_received;
    assign bus.dmem_txStartN = !(rstN && (state_q == EXEC) && bus.processDone);

    assign bus.state        = state_q;
    assign bus.timeDuration = time_q;
    assign bus.runCount     = runs_q;
    assign bus.timeout      = timeout_q;
endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: three instances sharing one stimulus stream
//   u0 : defaults (no watchdog)
//   u1 : TIMEOUT_CYCLES=50
//   u2 : TIME_WIDTH=4 (saturation)
// Directed run/rerun/watchdog/race/reset scenarios, then random traffic,
// all compared every cycle against a per-instance reference model.
module tb_run_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstN, startN, rerunN, ins, drx, dtx, pdone;
    logic [11:0] uart_addr, proc_addr;
    logic [47:0] uart_data, proc_data;
    logic        uart_wrEn, proc_wrEn;

    run_sequencer_if                   if0 ();
    run_sequencer_if                   if1 ();
    run_sequencer_if #(.TIME_WIDTH(4)) if2 ();

    run_sequencer                       u0 (.clk(clk), .rstN(rstN), .bus(if0));
    run_sequencer #(.TIMEOUT_CYCLES(50)) u1 (.clk(clk), .rstN(rstN), .bus(if1));
    run_sequencer #(.TIME_WIDTH(4))      u2 (.clk(clk), .rstN(rstN), .bus(if2));

    assign if0.startN = startN; assign if1.startN = startN; assign if2.startN = startN;
    assign if0.rerunN = rerunN; assign if1.rerunN = rerunN; assign if2.rerunN = rerunN;
    assign if0.ins_received = ins; assign if1.ins_received = ins; assign if2.ins_received = ins;
    assign if0.data_received = drx; assign if1.data_received = drx; assign if2.data_received = drx;
    assign if0.data_transmitted = dtx; assign if1.data_transmitted = dtx; assign if2.data_transmitted = dtx;
    assign if0.processDone = pdone; assign if1.processDone = pdone; assign if2.processDone = pdone;
    assign if0.uart_addr = uart_addr; assign if1.uart_addr = uart_addr; assign if2.uart_addr = uart_addr;
    assign if0.proc_addr = proc_addr; assign if1.proc_addr = proc_addr; assign if2.proc_addr = proc_addr;
    assign if0.uart_data = uart_data; assign if1.uart_data = uart_data; assign if2.uart_data = uart_data;
    assign if0.proc_data = proc_data; assign if1.proc_data = proc_data; assign if2.proc_data = proc_data;
    assign if0.uart_wrEn = uart_wrEn; assign if1.uart_wrEn = uart_wrEn; assign if2.uart_wrEn = uart_wrEn;
    assign if0.proc_wrEn = proc_wrEn; assign if1.proc_wrEn = proc_wrEn; assign if2.proc_wrEn = proc_wrEn;

    int checks = 0;
    int errors = 0;

    // reference model: one entry per instance
    int TOS [3] = '{0, 50, 0};
    int TWS [3] = '{26, 26, 4};
    int m_st [3];
    int m_td [3];
    int m_rc [3];
    int m_to [3];
    int m_arm[3];
    int ps_cnt[3];
    int tx_cnt[3];

    task automatic chk(input int k, input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL dut%0d %s: observed %0h expected %0h", k, tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_td[k] = 0; m_rc[k] = 0; m_to[k] = 0; m_arm[k] = 0;
        end
    endtask

    // advance every model by one clock edge using the inputs present at that edge
    task automatic model_adv();
        for (int k = 0; k < 3; k++) begin
            int ns;
            int tmax;
            tmax = (1 << TWS[k]) - 1;
            if (!rstN) begin
                m_st[k] = 0; m_td[k] = 0; m_rc[k] = 0; m_to[k] = 0; m_arm[k] = 0;
            end else begin
                ns = m_st[k];
                case (m_st[k])
                    0: if (!startN) ns = 1;
                    1: if (ins) ns = 2;
                    2: if (drx) ns = 3;
                    3: if (pdone) ns = 4;
                       else if (TOS[k] > 0 && m_td[k] == TOS[k] - 1) ns = 6;
                    4: if (dtx) ns = 5;
                    5: if (m_arm[k] != 0) begin
                           if (!startN) ns = 1;
                           else if (!rerunN) ns = 2;
                       end
                    6: if (m_arm[k] != 0 && !startN) ns = 1;
                    default: ns = 0;
                endcase
                if (m_st[k] == 3 && ns == 4) m_rc[k] = (m_rc[k] + 1) % 256;
                if (m_st[k] == 3 && ns == 6) m_to[k] = 1;
                else if (m_st[k] != 3 && ns == 3) m_to[k] = 0;
                if (m_st[k] != 3 && ns == 3) m_td[k] = 0;
                else if (m_st[k] == 3 && m_td[k] < tmax) m_td[k] = m_td[k] + 1;
                if ((ns == 5 || ns == 6) && ns != m_st[k]) m_arm[k] = 0;
                else if (startN && rerunN) m_arm[k] = 1;
                m_st[k] = ns;
            end
        end
    endtask

    task automatic chk_dut(input int k, input logic [2:0] st, input logic [25:0] td, input logic [7:0] rc,
                           input logic to, input logic ps, input logic tx,
                           input logic [11:0] a, input logic [47:0] d, input logic we);
        logic        e_ps, e_tx, e_we;
        logic [11:0] e_a;
        logic [47:0] e_d;
        e_ps = rstN && m_st[k] == 2 && drx;
        e_tx = !(rstN && m_st[k] == 3 && pdone);
        e_a = '0; e_d = '0; e_we = 1'b0;
        if (rstN && (m_st[k] == 2 || m_st[k] == 4)) begin
            e_a = uart_addr; e_d = uart_data; e_we = uart_wrEn;
        end else if (rstN && m_st[k] == 3) begin
            e_a = proc_addr; e_d = proc_data; e_we = proc_wrEn;
        end
        chk(k, "state", 64'(st), 64'(m_st[k]));
        chk(k, "timeDuration", 64'(td), 64'(m_td[k]));
        chk(k, "runCount", 64'(rc), 64'(m_rc[k]));
        chk(k, "timeout", 64'(to), 64'(m_to[k]));
        chk(k, "processStart", 64'(ps), 64'(e_ps));
        chk(k, "dmem_txStartN", 64'(tx), 64'(e_tx));
        chk(k, "dataMemAddr", 64'(a), 64'(e_a));
        chk(k, "dataMemIn", 64'(d), 64'(e_d));
        chk(k, "dataMemWrEn", 64'(we), 64'(e_we));
        if (ps === 1'b1) ps_cnt[k]++;
        if (tx === 1'b0) tx_cnt[k]++;
    endtask

    task automatic check_all();
        chk_dut(0, if0.state, if0.timeDuration, if0.runCount, if0.timeout, if0.processStart,
                if0.dmem_txStartN, if0.dataMemAddr, if0.dataMemIn, if0.dataMemWrEn);
        chk_dut(1, if1.state, if1.timeDuration, if1.runCount, if1.timeout, if1.processStart,
                if1.dmem_txStartN, if1.dataMemAddr, if1.dataMemIn, if1.dataMemWrEn);
        chk_dut(2, if2.state, 26'(if2.timeDuration), if2.runCount, if2.timeout, if2.processStart,
                if2.dmem_txStartN, if2.dataMemAddr, if2.dataMemIn, if2.dataMemWrEn);
    endtask

    // one clock: fresh bus payloads, compare mid-cycle, then advance the model
    task automatic step();
        uart_addr = 12'($urandom); proc_addr = 12'($urandom);
        uart_data = {16'($urandom), 32'($urandom)};
        proc_data = {16'($urandom), 32'($urandom)};
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_adv();
        #1;
    endtask

    initial begin
        rstN = 1'b0; startN = 1'b1; rerunN = 1'b1;
        ins = 1'b0; drx = 1'b0; dtx = 1'b0; pdone = 1'b0;
        uart_wrEn = 1'b0; proc_wrEn = 1'b0;
        uart_addr = '0; proc_addr = '0; uart_data = '0; proc_data = '0;
        model_reset();
        for (int k = 0; k < 3; k++) begin ps_cnt[k] = 0; tx_cnt[k] = 0; end
        repeat (2) @(posedge clk);
        #1;
        // reset held: every output at its reset value, mux gated
        uart_wrEn = 1'b1; proc_wrEn = 1'b1;
        step();
        chk(0, "rst_state", 64'(if0.state), 64'(0));
        chk(0, "rst_txStartN", 64'(if0.dmem_txStartN), 64'(1));
        rstN = 1'b1;

        // full run
        startN = 1'b0; step(); startN = 1'b1;
        chk(0, "to_rx_imem", 64'(if0.state), 64'(1));
        drx = 1'b1; step(); drx = 1'b0;
        chk(0, "drx_ignored", 64'(if0.state), 64'(1));
        ins = 1'b1; step(); ins = 1'b0;
        chk(0, "to_rx_dmem", 64'(if0.state), 64'(2));
        uart_wrEn = 1'b0; proc_wrEn = 1'b1; #1;
        chk(0, "mux_we_uart0", 64'(if0.dataMemWrEn), 64'(0));
        uart_wrEn = 1'b1; #1;
        chk(0, "mux_we_uart1", 64'(if0.dataMemWrEn), 64'(1));
        chk(0, "mux_addr", 64'(if0.dataMemAddr), 64'(uart_addr));
        for (int k = 0; k < 3; k++) begin ps_cnt[k] = 0; tx_cnt[k] = 0; end
        drx = 1'b1; step(); drx = 1'b0;
        repeat (99) step();
        pdone = 1'b1; step(); pdone = 1'b0;
        chk(0, "run1_state", 64'(if0.state), 64'(4));
        chk(0, "run1_td", 64'(if0.timeDuration), 64'(100));
        chk(0, "run1_count", 64'(if0.runCount), 64'(1));
        chk(0, "run1_ps_pulses", 64'(ps_cnt[0]), 64'(1));
        chk(0, "run1_tx_pulses", 64'(tx_cnt[0]), 64'(1));
        chk(1, "wdog_state", 64'(if1.state), 64'(6));
        chk(1, "wdog_flag", 64'(if1.timeout), 64'(1));
        chk(1, "wdog_td", 64'(if1.timeDuration), 64'(50));
        chk(1, "wdog_we", 64'(if1.dataMemWrEn), 64'(0));
        chk(1, "wdog_tx_pulses", 64'(tx_cnt[1]), 64'(0));
        chk(2, "sat_td100", 64'(if2.timeDuration), 64'(15));

        // startN held low into FINISH; armed ERROR restarts
        dtx = 1'b1; startN = 1'b0; step(); dtx = 1'b0;
        chk(0, "to_finish", 64'(if0.state), 64'(5));
        chk(1, "err_restart", 64'(if1.state), 64'(1));
        step(); step();
        chk(0, "finish_hold", 64'(if0.state), 64'(5));
        startN = 1'b1; step();
        chk(0, "finish_arming", 64'(if0.state), 64'(5));
        rerunN = 1'b0; step(); rerunN = 1'b1;
        chk(0, "rerun_dmem", 64'(if0.state), 64'(2));
        drx = 1'b1; step(); drx = 1'b0;
        repeat (19) step();
        pdone = 1'b1; step(); pdone = 1'b0;
        chk(0, "run2_count", 64'(if0.runCount), 64'(2));
        chk(0, "run2_td", 64'(if0.timeDuration), 64'(20));
        chk(2, "sat_td20", 64'(if2.timeDuration), 64'(15));
        chk(1, "rx_imem_ign", 64'(if1.state), 64'(1));

        // watchdog race: done in the 50th EXEC cycle wins
        rstN = 1'b0; step(); rstN = 1'b1;
        chk(1, "rst_timeout", 64'(if1.timeout), 64'(0));
        startN = 1'b0; step(); startN = 1'b1;
        ins = 1'b1; step(); ins = 1'b0;
        drx = 1'b1; step(); drx = 1'b0;
        repeat (49) step();
        pdone = 1'b1; step(); pdone = 1'b0;
        chk(1, "race_state", 64'(if1.state), 64'(4));
        chk(1, "race_timeout", 64'(if1.timeout), 64'(0));
        chk(1, "race_td", 64'(if1.timeDuration), 64'(50));

        // reset in EXEC coinciding with processDone
        dtx = 1'b1; step(); dtx = 1'b0;
        step();
        startN = 1'b0; step(); startN = 1'b1;
        ins = 1'b1; step(); ins = 1'b0;
        drx = 1'b1; step(); drx = 1'b0;
        repeat (5) step();
        rstN = 1'b0; pdone = 1'b1; #1;
        chk(0, "rst_exec_tx", 64'(if0.dmem_txStartN), 64'(1));
        step();
        rstN = 1'b1; pdone = 1'b0;
        chk(0, "rst_exec_state", 64'(if0.state), 64'(0));
        chk(0, "rst_exec_count", 64'(if0.runCount), 64'(0));

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rstN   = ($urandom_range(0, 199) != 0);
            startN = ($urandom_range(0, 9) != 0);
            rerunN = ($urandom_range(0, 7) != 0);
            ins    = ($urandom_range(0, 3) == 0);
            drx    = ($urandom_range(0, 3) == 0);
            dtx    = ($urandom_range(0, 3) == 0);
            pdone  = ($urandom_range(0, 39) == 0);
            uart_wrEn = 1'($urandom);
            proc_wrEn = 1'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/run_sequencer.md
RUN_SEQUENCER -- requirements
Module: run_sequencer

Interface
REQ-001 Parameter DATA_MEM_WIDTH, default 48: data memory word width in bits.
REQ-002 Parameter DATA_MEM_ADDR_WIDTH, default 12: data memory address width.
REQ-003 Parameter TIME_WIDTH, default 26: execution cycle counter width.
REQ-004 Parameter TIMEOUT_CYCLES, default 0: watchdog limit in EXEC; 0 disables the watchdog.
REQ-005 Parameter RUN_COUNT_WIDTH, default 8: completed-run counter width.
REQ-006 clk  in  1  single system clock; all logic on rising edge.
REQ-007 rstN  in  1  synchronous active-low reset.
REQ-008 startN  in  1  active-low full-load/run request (level).
REQ-009 rerunN  in  1  active-low rerun request: reload data memory only, keep instruction memory.
REQ-010 ins_received, data_received, data_transmitted  in  1 each  one-cycle done pulses from the UART memory interfaces.
REQ-011 processDone  in  1  processor completion pulse.
REQ-012 uart_addr, proc_addr  in  DATA_MEM_ADDR_WIDTH  candidate data memory addresses.
REQ-013 uart_data, proc_data  in  DATA_MEM_WIDTH  candidate data memory write data.
REQ-014 uart_wrEn, proc_wrEn  in  1  candidate data memory write enables.
REQ-015 dataMemAddr, dataMemIn, dataMemWrEn  out  widths as above  muxed data memory port.
REQ-016 processStart  out  1  one-cycle processor start pulse.
REQ-017 dmem_txStartN  out  1  active-low one-cycle start of result transmission.
REQ-018 state  out  3  encoded current state.
REQ-019 timeDuration  out  TIME_WIDTH  cycles spent in the last or current EXEC.
REQ-020 runCount  out  RUN_COUNT_WIDTH  completed runs since reset.
REQ-021 timeout  out  1  sticky watchdog flag.

Function
REQ-022 States and encodings: IDLE=0, RX_IMEM=1, RX_DMEM=2, EXEC=3, TX_DMEM=4, FINISH=5, ERROR=6; encoding 7 shall return to IDLE on the next cycle.
REQ-023 IDLE -> RX_IMEM when startN=0.
REQ-024 RX_IMEM -> RX_DMEM on ins_received; RX_DMEM -> EXEC on data_received.
REQ-025 EXEC -> TX_DMEM on processDone; TX_DMEM -> FINISH on data_transmitted.
REQ-026 FINISH and ERROR shall act on requests only once armed; the armed flag clears on entry to either state and sets once startN=1 and rerunN=1 are sampled together.
REQ-027 Armed FINISH: startN=0 -> RX_IMEM; otherwise rerunN=0 -> RX_DMEM; if both are low, startN wins.
REQ-028 Armed ERROR: startN=0 -> RX_IMEM; rerunN is ignored.
REQ-029 processStart shall be 1 combinationally only in the cycle where state=RX_DMEM and data_received=1.
REQ-030 dmem_txStartN shall be 0 combinationally only in the cycle where state=EXEC and processDone=1.
REQ-031 Memory mux: RX_DMEM or TX_DMEM selects uart_*; EXEC selects proc_*; all other states drive address 0, data 0 and wrEn 0.
REQ-032 timeDuration clears to 0 on the cycle EXEC is entered, increments by 1 each EXEC cycle, saturates at all-ones and holds outside EXEC.
REQ-033 With TIMEOUT_CYCLES>0, if timeDuration reaches TIMEOUT_CYCLES-1 in EXEC without processDone, the next state shall be ERROR and timeout shall set.
REQ-034 If processDone coincides with the timeout cycle, processDone wins: go to TX_DMEM and leave timeout unset.
REQ-035 timeout stays set until reset or the next entry to EXEC.
REQ-036 runCount increments, with wrap-around, on each EXEC->TX_DMEM transition.
REQ-037 Done pulses arriving in a non-matching state shall be ignored.

Reset
REQ-038 While rstN=0 at a clock edge: state=IDLE, timeDuration=0, runCount=0, timeout=0, armed=0, processStart=0, dmem_txStartN=1, mux outputs 0.
REQ-039 Reset mid-operation (any state) returns to IDLE on the next edge with all REQ-038 values, and no processStart or dmem_txStartN pulse in that cycle.

Verification
REQ-040 Full run: startN low, then pulses ins, data, processDone after 100 EXEC cycles, then data_transmitted -> states 0,1,2,3,4,5; one processStart pulse; one dmem_txStartN pulse; timeDuration=100; runCount=1.
REQ-041 Rerun: startN held low into FINISH, then released, then rerunN low -> stays in FINISH until release; then RX_DMEM (not RX_IMEM); runCount=2 after the second run.
REQ-042 Watchdog: TIMEOUT_CYCLES=50, no processDone -> ERROR after 50 EXEC cycles; timeout=1; dataMemWrEn=0 in ERROR; armed startN -> RX_IMEM.
REQ-043 Race: TIMEOUT_CYCLES=50, processDone on the 50th EXEC cycle -> TX_DMEM, timeout=0.
REQ-044 Mux and saturation: proc_wrEn=1 during RX_DMEM -> dataMemWrEn follows uart_wrEn only; TIME_WIDTH=4 with a 20-cycle EXEC -> timeDuration=15.
REQ-045 Reset asserted in EXEC with processDone=1 in the same cycle -> IDLE, dmem_txStartN=1, runCount=0.
